// File: rtl/alu_serial_ctrl_if.sv
// Command/response handshake bundle for alu_serial_ctrl.
// master = command source and result sink; slave = the controller.
interface alu_serial_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_result;
  logic             resp_carry;
  logic             resp_zero;
  logic             resp_ovf;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_carry, resp_zero, resp_ovf
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_result, resp_carry, resp_zero, resp_ovf
  );
endinterface

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer driving one shared 1-bit ALU slice, LSB first, with SLT fix-up.
// Optional abort input enabled by defining ALU_SERIAL_ABORT_EN.
module alu_serial_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = 5
) (
  input  logic       clk,
  input  logic       reset,
`ifdef ALU_SERIAL_ABORT_EN
  input  logic       abort,
`endif
  alu_serial_ctrl_if.slave bus,
  output logic       slice_a,
  output logic       slice_b,
  output logic [2:0] slice_sel,
  output logic       slice_cin,
  input  logic       slice_out,
  input  logic       slice_cout
);

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, sign_q, sign_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] rres_q, rres_d;
  logic             rcarry_q, rcarry_d, rzero_q, rzero_d, rovf_q, rovf_d;
  logic             arith, is_slt, last_bit, load_resp, clear, abort_hit;

`ifdef ALU_SERIAL_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  assign arith    = (op_q == 3'b000) || (op_q == 3'b001) || (op_q == 3'b011);
  assign is_slt   = (op_q == 3'b011);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  assign bus.resp_result = rres_q;
  assign bus.resp_carry  = rcarry_q;
  assign bus.resp_zero   = rzero_q;
  assign bus.resp_ovf    = rovf_q;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    sign_d    = sign_q;
    ovf_d     = ovf_q;
    rres_d    = rres_q;
    rcarry_d  = rcarry_q;
    rzero_d   = rzero_q;
    rovf_d    = rovf_q;
    load_resp = 1'b0;
    clear     = 1'b0;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    slice_a   = 1'b0;
    slice_b   = 1'b0;
    slice_sel = 3'b000;
    slice_cin = 1'b0;

    unique case (state_q)
      StIdle: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          op_d    = bus.req_op;
          a_d     = bus.req_a;
          b_d     = bus.req_b;
          res_d   = '0;
          cnt_d   = '0;
          // Subtraction is A + ~B + 1; the slice does the inversion.
          carry_d = (bus.req_op == 3'b001) || (bus.req_op == 3'b011);
          state_d = StRun;
        end
      end
      StRun: begin
        slice_a   = a_q[0];
        slice_b   = b_q[0];
        slice_cin = carry_q;
        slice_sel = is_slt ? 3'b001 : op_q;
        res_d     = {slice_out, res_q[WIDTH-1:1]};
        a_d       = a_q >> 1;
        b_d       = b_q >> 1;
        carry_d   = arith & slice_cout;
        cnt_d     = cnt_q + CW'(1);
        if (last_bit) begin
          sign_d = slice_out;
          ovf_d  = arith & (carry_q ^ slice_cout);
          if (is_slt) begin
            state_d = StFix;
          end else begin
            state_d   = StDone;
            load_resp = 1'b1;
          end
        end
        if (abort_hit) clear = 1'b1;
      end
      StFix: begin
        res_d     = WIDTH'(sign_q ^ ovf_q);
        state_d   = StDone;
        load_resp = 1'b1;
        if (abort_hit) clear = 1'b1;
      end
      StDone: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (load_resp) begin
      rres_d   = res_d;
      rcarry_d = carry_d;
      rovf_d   = ovf_d;
      rzero_d  = (res_d == '0);
    end

    if (clear) begin
      state_d  = StIdle;
      op_d     = '0;
      a_d      = '0;
      b_d      = '0;
      res_d    = '0;
      cnt_d    = '0;
      carry_d  = 1'b0;
      sign_d   = 1'b0;
      ovf_d    = 1'b0;
      rres_d   = '0;
      rcarry_d = 1'b0;
      rzero_d  = 1'b0;
      rovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      sign_q   <= 1'b0;
      ovf_q    <= 1'b0;
      rres_q   <= '0;
      rcarry_q <= 1'b0;
      rzero_q  <= 1'b0;
      rovf_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      sign_q   <= sign_d;
      ovf_q    <= ovf_d;
      rres_q   <= rres_d;
      rcarry_q <= rcarry_d;
      rzero_q  <= rzero_d;
      rovf_q   <= rovf_d;
    end
  end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed bench for alu_serial_ctrl with a behavioural 1-bit slice and a result scoreboard.
// Covers the abort path when ALU_SERIAL_ABORT_EN is defined.
module tb_alu_serial_ctrl;
  localparam int unsigned W = 8;

  typedef struct {
    logic [W-1:0] result;
    logic         carry;
    logic         zero;
    logic         ovf;
    int           lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       abort;
  logic       slice_a, slice_b, slice_cin, slice_out, slice_cout;
  logic [2:0] slice_sel;
  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  alu_serial_ctrl_if #(.WIDTH(W)) bus ();

  alu_serial_ctrl #(.WIDTH(W), .CW(5)) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef ALU_SERIAL_ABORT_EN
    .abort      (abort),
`endif
    .bus        (bus),
    .slice_a    (slice_a),
    .slice_b    (slice_b),
    .slice_sel  (slice_sel),
    .slice_cin  (slice_cin),
    .slice_out  (slice_out),
    .slice_cout (slice_cout)
  );

  // Behavioural 1-bit ALU slice; select 001 inverts B for subtraction.
  always_comb begin
    logic bb;
    bb         = slice_b ^ (slice_sel == 3'b001);
    slice_out  = 1'b0;
    slice_cout = 1'b0;
    case (slice_sel)
      3'b000, 3'b001: begin
        slice_out  = slice_a ^ bb ^ slice_cin;
        slice_cout = (slice_a & bb) | (slice_a & slice_cin) | (bb & slice_cin);
      end
      3'b010:  slice_out = slice_a ^ slice_b;
      3'b100:  slice_out = slice_a & slice_b;
      3'b101:  slice_out = ~(slice_a & slice_b);
      3'b110:  slice_out = ~(slice_a | slice_b);
      3'b111:  slice_out = slice_a | slice_b;
      default: slice_out = 1'b0;
    endcase
  end

  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t       e;
    logic [W:0] s;
    e.carry = 1'b0;
    e.ovf   = 1'b0;
    e.lat   = W + 1;
    e.result = '0;
    case (op)
      3'b000: begin
        s        = {1'b0, a} + {1'b0, b};
        e.result = s[W-1:0];
        e.carry  = s[W];
        e.ovf    = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
      end
      3'b001, 3'b011: begin
        s        = {1'b0, a} + {1'b0, ~b} + (W + 1)'(1);
        e.result = s[W-1:0];
        e.carry  = s[W];
        e.ovf    = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
        if (op == 3'b011) begin
          e.result = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
          e.lat    = W + 2;
        end
      end
      3'b010:  e.result = a ^ b;
      3'b100:  e.result = a & b;
      3'b101:  e.result = ~(a & b);
      3'b110:  e.result = ~(a | b);
      default: e.result = a | b;
    endcase
    e.zero = (e.result == '0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 1);
    chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 0);
    chk({tag, "_resp_result"}, 32'(bus.resp_result), 0);
    chk({tag, "_flags"}, {29'd0, bus.resp_carry, bus.resp_zero, bus.resp_ovf}, 0);
    chk({tag, "_slice"}, {28'd0, slice_a, slice_b, slice_cin, slice_sel != 3'b000}, 0);
  endtask

  // Present one command and let it be accepted; returns #1 after the accept edge.
  task automatic start(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    chk("req_ready_idle", 32'(bus.req_ready), 1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_op    = 3'($urandom_range(7));
    bus.req_a     = W'($urandom);
    bus.req_b     = W'($urandom);
    chk("slice_sel_run", 32'(slice_sel), (op == 3'b011) ? 32'd1 : 32'(op));
    chk("req_ready_run", 32'(bus.req_ready), 0);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold);
    exp_t e;
    int   lat;
    sb.push_back(model(op, a, b));
    start(op, a, b);
    lat = 1;
    while (!bus.resp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(sb[0].lat));
    if (!bus.resp_valid) begin
      void'(sb.pop_front());
      return;
    end
    repeat (hold) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(bus.resp_valid), 1);
      chk("hold_req_ready", 32'(bus.req_ready), 0);
      chk("hold_result", 32'(bus.resp_result), 32'(sb[0].result));
      chk("hold_flags", {29'd0, bus.resp_carry, bus.resp_zero, bus.resp_ovf},
          {29'd0, sb[0].carry, sb[0].zero, sb[0].ovf});
    end
    @(negedge clk);
    bus.resp_ready = 1'b1;
    e = sb.pop_front();
    chk("result", 32'(bus.resp_result), 32'(e.result));
    chk("carry", 32'(bus.resp_carry), 32'(e.carry));
    chk("zero", 32'(bus.resp_zero), 32'(e.zero));
    chk("ovf", 32'(bus.resp_ovf), 32'(e.ovf));
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    chk("post_valid", 32'(bus.resp_valid), 0);
    chk("post_req_ready", 32'(bus.req_ready), 1);
    chk("post_result_kept", 32'(bus.resp_result), 32'(e.result));
  endtask

  initial begin
    reset          = 1'b1;
    abort          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_op     = 3'b000;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_values("reset");
    @(negedge clk);
    reset = 1'b0;

    run_op(3'b000, 8'hFF, 8'h01, 0);
    run_op(3'b001, 8'h80, 8'h01, 0);
    run_op(3'b001, 8'h05, 8'h05, 0);
    run_op(3'b011, 8'h80, 8'h01, 0);
    run_op(3'b011, 8'h01, 8'h80, 0);
    run_op(3'b100, 8'hF0, 8'h3C, 0);
    run_op(3'b101, 8'hF0, 8'h3C, 0);
    run_op(3'b110, 8'hF0, 8'h3C, 0);
    run_op(3'b111, 8'hF0, 8'h3C, 0);
    run_op(3'b010, 8'hF0, 8'h3C, 0);
    run_op(3'b000, 8'h7F, 8'h01, 5);

    // Reset in the middle of RUN after three bits.
    start(3'b000, 8'h55, 8'h0F);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_values("midrun_reset");
    @(negedge clk);
    reset = 1'b0;
    run_op(3'b000, 8'h12, 8'h34, 0);

`ifdef ALU_SERIAL_ABORT_EN
    begin
      logic seen;
      seen = 1'b0;
      start(3'b000, 8'h12, 8'h34);
      repeat (3) @(posedge clk);
      @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      chk("abort_req_ready", 32'(bus.req_ready), 1);
      chk("abort_result", 32'(bus.resp_result), 0);
      repeat (W + 3) begin
        @(posedge clk);
        #1;
        if (bus.resp_valid) seen = 1'b1;
      end
      chk("abort_no_valid", 32'(seen), 0);
      run_op(3'b001, 8'h10, 8'h20, 0);
    end
`endif

    for (int i = 0; i < 10; i++) begin
      run_op(3'($urandom_range(7)), W'($urandom), W'($urandom), i % 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
